tl45_memory: RTL and testbench
==============================

# tl45_memory

Memory-access stage of the TL45 pipeline, placed directly downstream of the ALU stage and upstream of writeback. Register-to-register results pass through with one cycle of latency. Word loads and stores are executed as single Wishbone pipelined-mode transactions, and the stage stalls upstream until each transaction completes. The stage also drives the operand-forward bus and flags bus errors, misalignment and timeouts.

## Interface
- `TIMEOUT`, default 255: cycles to wait for ack/err in `ACK` before declaring a timeout (1..255).
- `i_clk` in 1: sole clock; all state changes on rising edge.
- `i_reset_n` in 1: synchronous, active-low reset.
- `i_pipe_stall` in 1: downstream stall; hold outputs, start nothing new.
- `i_pipe_flush` in 1: downstream flush; abort any bus cycle, clear the stage.
- `o_pipe_stall` out 1: `i_pipe_stall` OR (internal busy).
- `o_pipe_flush` out 1: equals `i_pipe_flush`.
- `i_opcode` in 5: LW = 5'h14, SW = 5'h15; any other value is pass-through.
- `i_dr` in 4: destination register; 0 means no write.
- `i_value` in 32: ALU result; for LW/SW this is the byte address.
- `i_st_val` in 32: store data.
- `o_of_reg` out 4: forward register number; 0 means invalid.
- `o_of_val` out 32: forward value.
- `o_dr` out 4: writeback register.
- `o_value` out 32: writeback value.
- `o_bus_err` out 1: one-cycle pulse on err, misalignment or timeout.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we` out 1 each.
- `o_wb_addr` out 30: word address.
- `o_wb_data` out 32: write data.
- `o_wb_sel` out 4: byte select.
- `i_wb_ack`, `i_wb_stall`, `i_wb_err` in 1 each.
- `i_wb_data` in 32: read data.

## Operation
- FSM states: `IDLE`, `REQ`, `ACK`, `DONE`. Registers: state, Wishbone outputs, `rdata`, 8-bit timeout counter, `err`.
- **`IDLE`, non-memory op, no stall:** at the clock edge, `o_dr` <= `i_dr` and `o_value` <= `i_value`. Combinationally, `o_of_reg` = `i_dr` and `o_of_val` = `i_value`.
- **`IDLE`, LW/SW with `i_value[1:0]` != 0 (misaligned):**
  - No bus cycle is issued. `o_bus_err` pulses next cycle and the FSM goes to `DONE`.
  - `rdata` = 0.
- **`IDLE`, aligned LW/SW, no stall:** register the following and go to `REQ`:
  - `o_wb_cyc` = `o_wb_stb` = 1.
  - `o_wb_we` = (SW).
  - `o_wb_addr` = `i_value[31:2]`.
  - `o_wb_data` = `i_st_val`.
  - `o_wb_sel` = 4'hF.
- **`REQ`:** hold `o_wb_stb` while `i_wb_stall` is high. When `i_wb_stall` is low, drop `o_wb_stb` and go to `ACK`. If ack/err arrives in the same cycle, treat it as completion, exactly as in `ACK`.
- **`ACK`:**
  - On `i_wb_ack`: `rdata` <= `i_wb_data`.
  - On `i_wb_err`: `rdata` <= 0 and pulse `o_bus_err`.
  - In both cases `o_wb_cyc` <= 0, then go to `DONE`.
  - If the counter reaches `TIMEOUT`: behave as err.
- **`DONE`:** `o_pipe_stall` is 0 (unless `i_pipe_stall` is high). At the edge:
  - `o_dr` <= (LW ? `i_dr` : 0).
  - `o_value` <= (LW ? `rdata` : 0).
  - Go to `IDLE`.
  - If `i_pipe_stall` is high, remain in `DONE`.
- **Forwarding:**
  - In `DONE` with LW: `o_of_reg` = `i_dr`, `o_of_val` = `rdata`.
  - In `REQ`/`ACK`, or for a memory op seen in `IDLE`: `o_of_reg` = 0, `o_of_val` = 0.
- **Internal busy:** high for a memory op in `IDLE`, and in `REQ` and `ACK`.
- **Bubbles:** while busy, `o_dr`/`o_value` are loaded with 0 each cycle.
- **Inputs under stall:** upstream holds all `i_*` stable while `o_pipe_stall` is high; the stage relies on that.
- **Reset / flush priority:** reset > flush > normal.
  - Either one forces `IDLE`, clears all Wishbone outputs, `o_dr`, `o_value`, `rdata`, counter and `o_bus_err`.
  - This applies in every state, including a flush mid-transaction, where the stage drops `cyc`.
  - A flush does not pulse `o_bus_err`.
- **Reset values:** every output is 0 (all output ports, including `o_wb_sel` = 0).

## Timing
- **Pass-through:** forward is combinational in the same cycle; writeback regs are valid 1 cycle later.
- **Aligned load, zero-wait slave:**

  | Cycle | Event |
  |---|---|
  | T0 | LW seen, stall = 1 |
  | T1 | `REQ`, stb accepted |
  | T2 | `ACK`, ack |
  | T3 | `DONE`, stall = 0, forward valid |
  | T4 | `o_dr`/`o_value` valid |

  Each cycle of `i_wb_stall` or ack delay adds one cycle.
- **Misaligned access:** T0 detect, T1 `DONE` with `o_bus_err` = 1, T2 outputs valid.
- **`o_wb_cyc`:** high from T1 until the cycle after ack/err/timeout. Never more than one outstanding request.
- **Timeout counter:** zeroed on entering `ACK`, increments each `ACK` cycle. Counter == `TIMEOUT` is the terminating cycle.

## Test plan
- ADD result: `i_dr` = 3, `i_value` = 0x1234 → same cycle `o_of_reg` = 3 / `o_of_val` = 0x1234. Next cycle `o_dr` = 3, `o_value` = 0x1234, stall never asserted.
- LW `i_value` = 0x100, `i_dr` = 5, slave returns 0xDEADBEEF with 2-cycle `i_wb_stall` and 1-cycle ack delay → `o_wb_addr` = 0x40, stall high 5 cycles, `o_dr` = 5, `o_value` = 0xDEADBEEF.
- SW `i_value` = 0x200, `i_st_val` = 0xA5A5A5A5 → `o_wb_we` = 1, `o_wb_data` = 0xA5A5A5A5, `o_wb_sel` = 0xF, `o_dr` = 0 after completion.
- LW `i_value` = 0x102 → no `o_wb_cyc`, `o_bus_err` pulse, `o_dr` = 5, `o_value` = 0. LW with a slave that never acks and `TIMEOUT` = 8 → `o_bus_err` after 8 `ACK` cycles, `cyc` dropped.
- `i_pipe_flush` during `ACK` → next cycle `cyc` = 0, state `IDLE`, outputs 0, no `o_bus_err`. `i_reset_n` = 0 mid-`REQ` → all outputs 0.
- `i_pipe_stall` held in `DONE` for 3 cycles → stays in `DONE`, no new bus cycle, `o_value` unchanged until release.

Source files
------------

// File: rtl/tl45_memory.sv
`default_nettype none
// tl45_memory: TL45 memory-access stage. Passes ALU results through and runs
// aligned LW/SW as single Wishbone pipelined transactions, stalling upstream meanwhile.
module tl45_memory #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  output logic        o_pipe_stall,
  output logic        o_pipe_flush,
  input  logic [4:0]  i_opcode,
  input  logic [3:0]  i_dr,
  input  logic [31:0] i_value,
  input  logic [31:0] i_st_val,
  output logic [3:0]  o_of_reg,
  output logic [31:0] o_of_val,
  output logic [3:0]  o_dr,
  output logic [31:0] o_value,
  output logic        o_bus_err,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [29:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data
);

  localparam logic [4:0] OP_LW       = 5'h14;
  localparam logic [4:0] OP_SW       = 5'h15;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] rdata;
  logic [7:0]  tmo_cnt;
  logic        err;

  logic is_lw;
  logic is_sw;
  logic is_mem;
  logic misaligned;
  logic busy;

  assign is_lw      = (i_opcode == OP_LW);
  assign is_sw      = (i_opcode == OP_SW);
  assign is_mem     = is_lw | is_sw;
  assign misaligned = (i_value[1:0] != 2'b00);
  assign busy       = ((state == IDLE) && is_mem) || (state == REQ) || (state == ACK);

  assign o_pipe_stall = i_pipe_stall | busy;
  assign o_pipe_flush = i_pipe_flush;
  assign o_bus_err    = err;

  always_comb begin
    o_of_reg = 4'd0;
    o_of_val = 32'd0;
    case (state)
      IDLE: begin
        if (!is_mem) begin
          o_of_reg = i_dr;
          o_of_val = i_value;
        end
      end
      DONE: begin
        if (is_lw) begin
          o_of_reg = i_dr;
          o_of_val = rdata;
        end
      end
      default: begin
        o_of_reg = 4'd0;
        o_of_val = 32'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    // Reset and flush have identical effect; reset simply wins if both are present.
    if (!i_reset_n || i_pipe_flush) begin
      state     <= IDLE;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_addr <= 30'd0;
      o_wb_data <= 32'd0;
      o_wb_sel  <= 4'd0;
      o_dr      <= 4'd0;
      o_value   <= 32'd0;
      rdata     <= 32'd0;
      tmo_cnt   <= 8'd0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_pipe_stall) begin
            if (is_mem) begin
              o_dr    <= 4'd0;
              o_value <= 32'd0;
              if (misaligned) begin
                rdata <= 32'd0;
                err   <= 1'b1;
                state <= DONE;
              end else begin
                o_wb_cyc  <= 1'b1;
                o_wb_stb  <= 1'b1;
                o_wb_we   <= is_sw;
                o_wb_addr <= i_value[31:2];
                o_wb_data <= i_st_val;
                o_wb_sel  <= 4'hF;
                state     <= REQ;
              end
            end else begin
              o_dr    <= i_dr;
              o_value <= i_value;
            end
          end
        end

        REQ: begin
          // Bubbles go downstream only when it is accepting them.
          if (!i_pipe_stall) begin
            o_dr    <= 4'd0;
            o_value <= 32'd0;
          end
          if (i_wb_err) begin
            o_wb_stb <= 1'b0;
            o_wb_cyc <= 1'b0;
            rdata    <= 32'd0;
            err      <= 1'b1;
            state    <= DONE;
          end else if (i_wb_ack) begin
            o_wb_stb <= 1'b0;
            o_wb_cyc <= 1'b0;
            rdata    <= i_wb_data;
            state    <= DONE;
          end else if (!i_wb_stall) begin
            o_wb_stb <= 1'b0;
            tmo_cnt  <= 8'd0;
            state    <= ACK;
          end
        end

        ACK: begin
          if (!i_pipe_stall) begin
            o_dr    <= 4'd0;
            o_value <= 32'd0;
          end
          if (i_wb_err || (!i_wb_ack && (tmo_cnt == TIMEOUT_CNT))) begin
            o_wb_cyc <= 1'b0;
            rdata    <= 32'd0;
            err      <= 1'b1;
            state    <= DONE;
          end else if (i_wb_ack) begin
            o_wb_cyc <= 1'b0;
            rdata    <= i_wb_data;
            state    <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        DONE: begin
          if (!i_pipe_stall) begin
            o_dr    <= is_lw ? i_dr : 4'd0;
            o_value <= is_lw ? rdata : 32'd0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tl45_memory.sv
`default_nettype none
// tb_tl45_memory: directed self-checking bench for tl45_memory with a small
// cycle-stepped Wishbone slave.
module tb_tl45_memory;

  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_LW  = 5'h14;
  localparam logic [4:0] OP_SW  = 5'h15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pipe_stall_in;
  logic        pipe_flush_in;
  logic        pipe_stall_out;
  logic        pipe_flush_out;
  logic [4:0]  opcode;
  logic [3:0]  dr_in;
  logic [31:0] value_in;
  logic [31:0] st_val;
  logic [3:0]  of_reg;
  logic [31:0] of_val;
  logic [3:0]  dr_out;
  logic [31:0] value_out;
  logic        bus_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [29:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_sel;
  logic        wb_ack;
  logic        wb_stall;
  logic        wb_err;
  logic [31:0] wb_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tl45_memory #(.TIMEOUT(8)) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_pipe_stall (pipe_stall_in),
    .i_pipe_flush (pipe_flush_in),
    .o_pipe_stall (pipe_stall_out),
    .o_pipe_flush (pipe_flush_out),
    .i_opcode     (opcode),
    .i_dr         (dr_in),
    .i_value      (value_in),
    .i_st_val     (st_val),
    .o_of_reg     (of_reg),
    .o_of_val     (of_val),
    .o_dr         (dr_out),
    .o_value      (value_out),
    .o_bus_err    (bus_err),
    .o_wb_cyc     (wb_cyc),
    .o_wb_stb     (wb_stb),
    .o_wb_we      (wb_we),
    .o_wb_addr    (wb_addr),
    .o_wb_data    (wb_wdata),
    .o_wb_sel     (wb_sel),
    .i_wb_ack     (wb_ack),
    .i_wb_stall   (wb_stall),
    .i_wb_err     (wb_err),
    .i_wb_data    (wb_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    opcode   = OP_ADD;
    dr_in    = 4'd0;
    value_in = 32'd0;
    st_val   = 32'd0;
    wb_ack   = 1'b0;
    wb_stall = 1'b0;
    wb_err   = 1'b0;
    wb_rdata = 32'd0;
  endtask

  // Presents a memory op and plays the slave until the stage releases its stall.
  // Slave stall is high for the first n_stall cycles counted from the issue cycle;
  // the response comes ack_dly cycles after the first ACK-state cycle.
  task automatic run_mem(input logic [4:0] op, input logic [3:0] dr, input logic [31:0] adr,
                         input logic [31:0] st, input logic [31:0] rd, input int n_stall,
                         input int ack_dly, input bit give_err, input bit no_resp,
                         output int stall_cyc, output int cyc_cyc, output int err_cyc,
                         output logic [31:0] req_addr, output logic req_we,
                         output logic [31:0] req_data, output logic [3:0] req_sel);
    int acc;
    bit done;
    bit resp;
    acc = -1; done = 0;
    stall_cyc = 0; cyc_cyc = 0; err_cyc = 0;
    req_addr = 32'd0; req_we = 1'b0; req_data = 32'd0; req_sel = 4'd0;
    opcode = op; dr_in = dr; value_in = adr; st_val = st;
    for (int k = 0; k < 64 && !done; k++) begin
      resp     = !no_resp && (acc >= 0) && (k == acc + 1 + ack_dly);
      wb_stall = (k < n_stall) ? 1'b1 : 1'b0;
      wb_ack   = (resp && !give_err) ? 1'b1 : 1'b0;
      wb_err   = (resp && give_err) ? 1'b1 : 1'b0;
      wb_rdata = (resp && !give_err) ? rd : 32'd0;
      #1;
      if (pipe_stall_out) stall_cyc++;
      if (wb_cyc) cyc_cyc++;
      if (bus_err) err_cyc++;
      if (wb_stb) begin
        req_addr = {2'b00, wb_addr};
        req_we   = wb_we;
        req_data = wb_wdata;
        req_sel  = wb_sel;
        if (!wb_stall && acc < 0) acc = k;
      end
      if (!pipe_stall_out) done = 1;
      step();
    end
    if (!done) check("mem_op_bound", 32'd0, 32'd1);
    idle_inputs();
  endtask

  int          sc, cc, ec;
  logic [31:0] ra, rdv;
  logic        rw;
  logic [3:0]  rs;

  initial begin
    reset_n       = 1'b0;
    pipe_stall_in = 1'b0;
    pipe_flush_in = 1'b0;
    idle_inputs();
    opcode = 5'd0;
    step(); step();

    // Reset state
    check("rst_dr", {28'd0, dr_out}, 32'd0);
    check("rst_value", value_out, 32'd0);
    check("rst_cyc_stb_we_err", {28'd0, wb_cyc, wb_stb, wb_we, bus_err}, 32'd0);
    check("rst_sel", {28'd0, wb_sel}, 32'd0);
    check("rst_addr", {2'b00, wb_addr}, 32'd0);
    check("rst_stall", {31'd0, pipe_stall_out}, 32'd0);
    reset_n = 1'b1;
    step();

    // Pass-through ADD
    opcode = OP_ADD; dr_in = 4'd3; value_in = 32'h1234;
    #1;
    check("add_of_reg", {28'd0, of_reg}, 32'd3);
    check("add_of_val", of_val, 32'h1234);
    check("add_stall", {31'd0, pipe_stall_out}, 32'd0);
    step();
    check("add_dr", {28'd0, dr_out}, 32'd3);
    check("add_value", value_out, 32'h1234);
    idle_inputs();
    step();

    // LW with slave stall and one-cycle ack delay
    run_mem(OP_LW, 4'd5, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1, 0, 0, sc, cc, ec, ra, rw, rdv, rs);
    check("lw_addr", ra, 32'h40);
    check("lw_we", {31'd0, rw}, 32'd0);
    check("lw_sel", {28'd0, rs}, 32'hF);
    check("lw_stall_cycles", sc, 32'd5);
    check("lw_dr", {28'd0, dr_out}, 32'd5);
    check("lw_value", value_out, 32'hDEADBEEF);
    check("lw_no_err", ec, 32'd0);
    step();

    // SW zero-wait
    run_mem(OP_SW, 4'd0, 32'h200, 32'hA5A5A5A5, 32'h0, 0, 0, 0, 0, sc, cc, ec, ra, rw, rdv, rs);
    check("sw_we", {31'd0, rw}, 32'd1);
    check("sw_data", rdv, 32'hA5A5A5A5);
    check("sw_sel", {28'd0, rs}, 32'hF);
    check("sw_addr", ra, 32'h80);
    check("sw_stall_cycles", sc, 32'd3);
    check("sw_dr", {28'd0, dr_out}, 32'd0);
    check("sw_value", value_out, 32'd0);
    step();

    // Misaligned LW
    run_mem(OP_LW, 4'd5, 32'h102, 32'h0, 32'h0, 0, 0, 0, 0, sc, cc, ec, ra, rw, rdv, rs);
    check("mis_no_cyc", cc, 32'd0);
    check("mis_err_pulse", ec, 32'd1);
    check("mis_stall_cycles", sc, 32'd1);
    check("mis_dr", {28'd0, dr_out}, 32'd5);
    check("mis_value", value_out, 32'd0);
    check("mis_err_cleared", {31'd0, bus_err}, 32'd0);
    step();

    // Timeout: ACK cycles with counter 0..8, then DONE
    run_mem(OP_LW, 4'd7, 32'h300, 32'h0, 32'h0, 0, 0, 0, 1, sc, cc, ec, ra, rw, rdv, rs);
    check("tmo_err_pulse", ec, 32'd1);
    check("tmo_cyc_cycles", cc, 32'd10);
    check("tmo_stall_cycles", sc, 32'd11);
    check("tmo_cyc_dropped", {31'd0, wb_cyc}, 32'd0);
    check("tmo_value", value_out, 32'd0);
    step();

    // Slave error response
    run_mem(OP_LW, 4'd6, 32'h400, 32'h0, 32'h0, 0, 0, 1, 0, sc, cc, ec, ra, rw, rdv, rs);
    check("err_pulse", ec, 32'd1);
    check("err_dr", {28'd0, dr_out}, 32'd6);
    check("err_value", value_out, 32'd0);
    step();

    // Flush during ACK
    opcode = OP_LW; dr_in = 4'd9; value_in = 32'h500;
    step();                       // REQ, accepted (slave not stalling)
    step();                       // ACK
    check("fl_pre_cyc", {31'd0, wb_cyc}, 32'd1);
    pipe_flush_in = 1'b1;
    #1;
    check("fl_passthru", {31'd0, pipe_flush_out}, 32'd1);
    step();
    pipe_flush_in = 1'b0;
    opcode = OP_ADD; dr_in = 4'd2; value_in = 32'h77;
    #1;
    check("fl_cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd0);
    check("fl_no_err", {31'd0, bus_err}, 32'd0);
    check("fl_idle_stall", {31'd0, pipe_stall_out}, 32'd0);
    check("fl_idle_fwd", {28'd0, of_reg}, 32'd2);
    check("fl_dr_value", {dr_out, value_out[27:0]}, 32'd0);
    idle_inputs();
    step();

    // Reset mid-REQ
    opcode = OP_SW; dr_in = 4'd0; value_in = 32'h604; st_val = 32'h12345678;
    wb_stall = 1'b1;
    step();                       // REQ, held by slave stall
    check("rr_pre_stb", {31'd0, wb_stb}, 32'd1);
    reset_n = 1'b0;
    idle_inputs();
    opcode = 5'd0;
    step();
    check("rr_wb_ctl", {28'd0, wb_cyc, wb_stb, wb_we, bus_err}, 32'd0);
    check("rr_wb_addr", {2'b00, wb_addr}, 32'd0);
    check("rr_wb_data", wb_wdata, 32'd0);
    check("rr_wb_sel", {28'd0, wb_sel}, 32'd0);
    check("rr_dr_value", {dr_out, value_out[27:0]}, 32'd0);
    reset_n = 1'b1;
    step();

    // Downstream stall held three cycles in DONE
    opcode = OP_LW; dr_in = 4'd4; value_in = 32'h700;
    step();                       // REQ accepted
    wb_ack = 1'b1; wb_rdata = 32'h0BADF00D;
    step();                       // ACK with ack
    wb_ack = 1'b0; wb_rdata = 32'd0;
    pipe_stall_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("ds_hold_fwd", of_val, 32'h0BADF00D);
      check("ds_hold_cyc", {31'd0, wb_cyc}, 32'd0);
      check("ds_hold_value", value_out, 32'd0);
      step();
    end
    pipe_stall_in = 1'b0;
    #1;
    check("ds_release_stall", {31'd0, pipe_stall_out}, 32'd0);
    step();
    check("ds_dr", {28'd0, dr_out}, 32'd4);
    check("ds_value", value_out, 32'h0BADF00D);
    idle_inputs();
    step();
    check("ds_no_new_cyc", {31'd0, wb_cyc}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
